// File: rtl/hyperbus_tf_splitter.sv
// Splits one HyperBus transfer into sub-transfers bounded by a maximum word
// count and by the chip boundary 2^(msb+1) bytes. The word size is 2 B with
// one PHY and 4 B with two PHYs.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   cfg_max_words_i         max words per sub-transfer (0 = unlimited)
//   cfg_addr_mask_msb_i     chip boundary is 2^(msb+1) bytes
//   cfg_phys_in_use_i       0 = one PHY (2 B words), 1 = two PHYs (4 B words)
//   in_*                    parent transfer (valid/ready handshake)
//   out_*                   sub-transfer (valid/ready handshake), first/last markers
//   err_o                   one-cycle pulse when an illegal transfer is dropped
//   busy_o                  high while a transfer is being split
module hyperbus_tf_splitter #(
   parameter int unsigned NumPhys   = 2,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned BlenWidth = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [15:0]          cfg_max_words_i,
   input  logic [4:0]           cfg_addr_mask_msb_i,
   input  logic                 cfg_phys_in_use_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic                 in_write_i,
   input  logic                 in_burst_type_i,
   input  logic                 in_addr_space_i,
   input  logic [AddrWidth-1:0] in_addr_i,
   input  logic [BlenWidth-1:0] in_burst_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 out_write_o,
   output logic                 out_burst_type_o,
   output logic                 out_addr_space_o,
   output logic [AddrWidth-1:0] out_addr_o,
   output logic [BlenWidth-1:0] out_burst_o,
   output logic                 out_first_o,
   output logic                 out_last_o,
   output logic                 err_o,
   output logic                 busy_o
);

   // Common width for comparing remaining count, max words and boundary distance
   localparam int unsigned Aw1      = AddrWidth + 1;
   localparam int unsigned CmpWidth = (Aw1 > BlenWidth) ? ((Aw1 > 16) ? Aw1 : 16)
                                                       : ((BlenWidth > 16) ? BlenWidth : 16);

   typedef enum logic {StIdle, StSplit} state_e;

   state_e                 state_q, state_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [BlenWidth-1:0]   rem_q, rem_d;
   logic                   first_q, first_d;
   logic                   write_q, write_d;
   logic                   btype_q, btype_d;
   logic                   aspace_q, aspace_d;
   logic [15:0]            max_q, max_d;
   logic [4:0]             msb_q, msb_d;
   logic                   phys2_q, phys2_d;
   logic                   err_q, err_d;

   logic [BlenWidth-1:0]   chunk;
   logic                   last_c;
   logic [1:0]             word_shift;
   logic                   in_phys2;
   logic                   in_illegal;

   // State and latched-transfer registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         rem_q    <= '0;
         first_q  <= 1'b0;
         write_q  <= 1'b0;
         btype_q  <= 1'b0;
         aspace_q <= 1'b0;
         max_q    <= '0;
         msb_q    <= '0;
         phys2_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         first_q  <= first_d;
         write_q  <= write_d;
         btype_q  <= btype_d;
         aspace_q <= aspace_d;
         max_q    <= max_d;
         msb_q    <= msb_d;
         phys2_q  <= phys2_d;
         err_q    <= err_d;
      end
   end

   // A single-PHY build ignores the PHY selection input
   assign in_phys2   = (NumPhys > 1) && cfg_phys_in_use_i;
   assign in_illegal = (in_burst_i == '0) ||
                       (in_phys2 ? (in_addr_i[1:0] != 2'b00) : in_addr_i[0]);
   assign word_shift = phys2_q ? 2'd2 : 2'd1;

   // Chunk length from latched state: min(remaining, max words, words to boundary)
   always_comb begin
      logic [5:0]          msb_p1;
      logic [CmpWidth-1:0] bound_bytes;
      logic [CmpWidth-1:0] offset;
      logic [CmpWidth-1:0] to_bound;
      logic [CmpWidth-1:0] chunk_w;
      msb_p1      = 6'(msb_q) + 6'd1;
      bound_bytes = '0;
      offset      = '0;
      to_bound    = '1;
      // Boundary beyond the address space never limits the chunk
      if (32'(msb_p1) <= AddrWidth) begin
         bound_bytes = CmpWidth'(1) << msb_p1;
         offset      = CmpWidth'(addr_q) & (bound_bytes - CmpWidth'(1));
         to_bound    = (bound_bytes - offset) >> word_shift;
      end
      chunk_w = CmpWidth'(rem_q);
      if ((max_q != 16'd0) && (CmpWidth'(max_q) < chunk_w)) begin
         chunk_w = CmpWidth'(max_q);
      end
      if (to_bound < chunk_w) begin
         chunk_w = to_bound;
      end
      chunk  = BlenWidth'(chunk_w);
      last_c = (chunk == rem_q);
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      first_d  = first_q;
      write_d  = write_q;
      btype_d  = btype_q;
      aspace_d = aspace_q;
      max_d    = max_q;
      msb_d    = msb_q;
      phys2_d  = phys2_q;
      err_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               addr_d   = in_addr_i;
               rem_d    = in_burst_i;
               write_d  = in_write_i;
               btype_d  = in_burst_type_i;
               aspace_d = in_addr_space_i;
               max_d    = cfg_max_words_i;
               msb_d    = cfg_addr_mask_msb_i;
               phys2_d  = in_phys2;
               if (in_illegal) begin
                  err_d = 1'b1;
               end else begin
                  first_d = 1'b1;
                  state_d = StSplit;
               end
            end
         end
         StSplit: begin
            if (out_ready_i) begin
               addr_d  = addr_q + (AddrWidth'(chunk) << word_shift);
               rem_d   = rem_q - chunk;
               first_d = 1'b0;
               if (last_c) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_ready_o       = (state_q == StIdle);
   assign out_valid_o      = (state_q == StSplit);
   assign busy_o           = (state_q != StIdle);
   assign out_write_o      = write_q;
   assign out_burst_type_o = btype_q;
   assign out_addr_space_o = aspace_q;
   assign out_addr_o       = addr_q;
   assign out_burst_o      = chunk;
   assign out_first_o      = (state_q == StSplit) && first_q;
   assign out_last_o       = (state_q == StSplit) && last_c;
   assign err_o            = err_q;

endmodule

// File: tb/tb_hyperbus_tf_splitter.sv
// Scoreboard bench for hyperbus_tf_splitter: directed transfers push their
// hand-computed sub-transfers; a monitor pops and compares on each output handshake.
module tb_hyperbus_tf_splitter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cfg_max;
   logic [4:0]  cfg_msb;
   logic        cfg_phys;
   logic        in_valid;
   logic        in_ready;
   logic        in_write;
   logic        in_btype;
   logic        in_aspace;
   logic [31:0] in_addr;
   logic [14:0] in_burst;
   logic        out_valid;
   logic        out_ready;
   logic        out_write;
   logic        out_btype;
   logic        out_aspace;
   logic [31:0] out_addr;
   logic [14:0] out_burst;
   logic        out_first;
   logic        out_last;
   logic        err;
   logic        busy;

   typedef struct packed {
      logic [31:0] addr;
      logic [14:0] burst;
      logic        first;
      logic        last;
      logic        write;
      logic        btype;
      logic        aspace;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic err_allow = 1'b0;

   always #5 clk = ~clk;

   hyperbus_tf_splitter #(.NumPhys(2), .AddrWidth(32), .BlenWidth(15)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cfg_max_words_i(cfg_max), .cfg_addr_mask_msb_i(cfg_msb), .cfg_phys_in_use_i(cfg_phys),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_write_i(in_write), .in_burst_type_i(in_btype), .in_addr_space_i(in_aspace),
      .in_addr_i(in_addr), .in_burst_i(in_burst),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_write_o(out_write), .out_burst_type_o(out_btype), .out_addr_space_o(out_aspace),
      .out_addr_o(out_addr), .out_burst_o(out_burst),
      .out_first_o(out_first), .out_last_o(out_last),
      .err_o(err), .busy_o(busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
      end
   endtask

   // Monitor: compare every output handshake against the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_subtransfer", {32'd0, out_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_addr",   64'(out_addr),   64'(e.addr));
            chk("out_burst",  64'(out_burst),  64'(e.burst));
            chk("out_first",  64'(out_first),  64'(e.first));
            chk("out_last",   64'(out_last),   64'(e.last));
            chk("out_write",  64'(out_write),  64'(e.write));
            chk("out_btype",  64'(out_btype),  64'(e.btype));
            chk("out_aspace", 64'(out_aspace), 64'(e.aspace));
         end
      end
      if (rst_n && err && !err_allow) begin
         chk("unexpected_err", 64'(err), 64'd0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_cfg(input logic [15:0] mx, input logic [4:0] msb, input logic phys);
      cfg_max  = mx;
      cfg_msb  = msb;
      cfg_phys = phys;
   endtask

   task automatic push(input logic [31:0] a, input logic [14:0] b, input logic f, input logic l,
                       input logic [2:0] attr);
      exp_t e;
      e.addr = a; e.burst = b; e.first = f; e.last = l;
      e.write = attr[2]; e.btype = attr[1]; e.aspace = attr[0];
      exp_q.push_back(e);
   endtask

   // Returns one cycle after the accepting edge (cycle T+1, #1)
   task automatic send(input logic [31:0] a, input logic [14:0] b, input logic [2:0] attr);
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         cyc(1);
         t++;
      end
      if (!in_ready) chk("send_wait_in_ready", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      in_addr   = a;
      in_burst  = b;
      in_write  = attr[2];
      in_btype  = attr[1];
      in_aspace = attr[0];
      cyc(1);
      in_valid  = 1'b0;
      in_addr   = 32'hDEAD_BEEF;
      in_burst  = 15'h7FFF;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 100) begin
         cyc(1);
         t++;
      end
      chk("drain_busy", 64'(busy), 64'd0);
      chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic send_err(input string name, input logic [31:0] a, input logic [14:0] b);
      err_allow = 1'b1;
      send(a, b, 3'b000);
      chk({name, "_err_pulse"}, 64'(err), 64'd1);
      chk({name, "_no_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
      cyc(1);
      chk({name, "_err_single"}, 64'(err), 64'd0);
      chk({name, "_no_valid2"}, 64'(out_valid), 64'd0);
      err_allow = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_write = 1'b0; in_btype = 1'b0; in_aspace = 1'b0;
      in_addr = '0; in_burst = '0; out_ready = 1'b1;
      set_cfg(16'd0, 5'd25, 1'b0);
      cyc(2);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("rst_out_burst", 64'(out_burst), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      rst_n = 1'b1;
      cyc(1);

      // 1 PHY, unlimited, single sub-transfer
      set_cfg(16'd0, 5'd25, 1'b0);
      push(32'h100, 15'd8, 1'b1, 1'b1, 3'b101);
      send(32'h100, 15'd8, 3'b101);
      chk("t1_valid_T1", 64'(out_valid), 64'd1);
      chk("t1_in_ready_low", 64'(in_ready), 64'd0);
      cyc(1);
      chk("t1_in_ready_T2", 64'(in_ready), 64'd1);
      chk("t1_valid_T2", 64'(out_valid), 64'd0);
      wait_idle();

      // 1 PHY, max 4 words, three back-to-back sub-transfers
      set_cfg(16'd4, 5'd25, 1'b0);
      push(32'h0,  15'd4, 1'b1, 1'b0, 3'b010);
      push(32'h8,  15'd4, 1'b0, 1'b0, 3'b010);
      push(32'h10, 15'd2, 1'b0, 1'b1, 3'b010);
      send(32'h0, 15'd10, 3'b010);
      chk("t2_valid_T1", 64'(out_valid), 64'd1);
      cyc(3);
      chk("t2_in_ready_T4", 64'(in_ready), 64'd1);
      chk("t2_consecutive", 64'(exp_q.size()), 64'd0);
      wait_idle();

      // 1 PHY, 1 KiB boundary
      set_cfg(16'd0, 5'd9, 1'b0);
      push(32'h3F8, 15'd4, 1'b1, 1'b0, 3'b001);
      push(32'h400, 15'd4, 1'b0, 1'b1, 3'b001);
      send(32'h3F8, 15'd8, 3'b001);
      wait_idle();

      // 2 PHYs, 1 KiB boundary, then a misaligned address
      set_cfg(16'd0, 5'd9, 1'b1);
      push(32'h3F8, 15'd2, 1'b1, 1'b0, 3'b100);
      push(32'h400, 15'd2, 1'b0, 1'b1, 3'b100);
      send(32'h3F8, 15'd4, 3'b100);
      wait_idle();
      send_err("misalign", 32'h3FA, 15'd4);

      // Backpressure on second chunk with config changed mid-transfer
      set_cfg(16'd4, 5'd25, 1'b0);
      push(32'h0,  15'd4, 1'b1, 1'b0, 3'b000);
      push(32'h8,  15'd4, 1'b0, 1'b0, 3'b000);
      push(32'h10, 15'd2, 1'b0, 1'b1, 3'b000);
      send(32'h0, 15'd10, 3'b000);
      cyc(1);
      out_ready = 1'b0;
      cfg_max   = 16'd1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_addr", 64'(out_addr), 64'h8);
         chk("bp_burst", 64'(out_burst), 64'd4);
         chk("bp_first_last", 64'({out_first, out_last}), 64'd0);
         cyc(1);
      end
      out_ready = 1'b1;
      wait_idle();

      // Zero-length burst
      send_err("burst0", 32'h40, 15'd0);

      // Reset asserted during the second chunk
      set_cfg(16'd4, 5'd25, 1'b0);
      push(32'h0, 15'd4, 1'b1, 1'b0, 3'b000);
      send(32'h0, 15'd10, 3'b000);
      cyc(1);
      out_ready = 1'b0;
      cyc(1);
      chk("rstmid_valid_before", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("rstmid_valid", 64'(out_valid), 64'd0);
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_out_addr", 64'(out_addr), 64'd0);
      chk("rstmid_out_burst", 64'(out_burst), 64'd0);
      out_ready = 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      chk("rstmid_in_ready", 64'(in_ready), 64'd1);
      chk("rstmid_valid_after", 64'(out_valid), 64'd0);

      // Recovery after reset
      set_cfg(16'd0, 5'd25, 1'b0);
      push(32'h100, 15'd8, 1'b1, 1'b1, 3'b000);
      send(32'h100, 15'd8, 3'b000);
      wait_idle();

      cyc(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
